// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer.
package int_pkg;

  // Sequencer state: running normal code or executing an interrupt handler
  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  // Handler entry addresses supplied by the arbiter for each request line
  localparam logic [31:0] IR1_ADDR = 32'h0000_0009;
  localparam logic [31:0] IR2_ADDR = 32'h0000_00C8;
  localparam logic [31:0] IR3_ADDR = 32'h0000_016C;

  // Fetch address after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Priority selector for the next fetch address and the pipeline flush pair.
// Interrupt entry beats handler return, which beats branch, jump and stall.
module next_pc_mux
  import int_pkg::*;
(
  input  state_t      state_i,
  input  logic        int_i,
  input  logic        eret_dec_i,
  input  logic        b_i,
  input  logic        j_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus1_i,
  input  logic [31:0] iaddr_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] baddr_i,
  input  logic [31:0] jaddr_i,
  output logic [31:0] next_pc_o,
  output logic        flush_ifid_o,
  output logic        flush_idex_o
);

  // First matching redirect wins; a stall only matters when nothing redirects
  always_comb begin
    next_pc_o    = pc_plus1_i;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    if (int_i && (state_i == RUN)) begin
      next_pc_o    = iaddr_i;
      flush_ifid_o = 1'b1;
      flush_idex_o = 1'b1;
    end else if (eret_dec_i && (state_i == HANDLER)) begin
      next_pc_o    = epc_i;
      flush_ifid_o = 1'b1;
      flush_idex_o = 1'b1;
    end else if (b_i) begin
      next_pc_o    = baddr_i;
      flush_ifid_o = 1'b1;
      flush_idex_o = 1'b1;
    end else if (j_i) begin
      next_pc_o    = jaddr_i;
      flush_ifid_o = 1'b1;
    end else if (stall_i) begin
      next_pc_o    = pc_i;
    end
  end

endmodule

// File: rtl/int_pc_seq.sv
// Interrupt entry/return sequencer: owns the PC register, tracks whether a
// handler is running, counts interrupts and handler cycles, and flags
// protocol misuse (interrupt inside a handler, ERET outside one).
module int_pc_seq
  import int_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             Int,
  input  logic [31:0]      Iaddr,
  input  logic [31:0]      EPC,
  input  logic             eret_dec,
  input  logic             J,
  input  logic [31:0]      Jaddr,
  input  logic             B,
  input  logic [31:0]      Baddr,
  input  logic             stall,
  output logic [31:0]      PC,
  output logic [31:0]      PC_plus1,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             eret,
  output logic             in_handler,
  output logic [7:0]       int_cnt,
  output logic [CNT_W-1:0] hcycles,
  output logic             err
);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             eret_q, eret_d;
  logic [7:0]       int_cnt_q, int_cnt_d;
  logic [CNT_W-1:0] hcycles_q, hcycles_d;
  logic             err_q, err_d;
  logic             mux_flush_ifid, mux_flush_idex;

  assign PC_plus1 = pc_q + 32'd1;

  next_pc_mux u_next_pc_mux (
    .state_i      (state_q),
    .int_i        (Int),
    .eret_dec_i   (eret_dec),
    .b_i          (B),
    .j_i          (J),
    .stall_i      (stall),
    .pc_i         (pc_q),
    .pc_plus1_i   (PC_plus1),
    .iaddr_i      (Iaddr),
    .epc_i        (EPC),
    .baddr_i      (Baddr),
    .jaddr_i      (Jaddr),
    .next_pc_o    (pc_d),
    .flush_ifid_o (mux_flush_ifid),
    .flush_idex_o (mux_flush_idex)
  );

  // Flushes are suppressed while CLR is held so the pipeline sees a quiet reset
  assign flush_ifid = mux_flush_ifid & ~CLR;
  assign flush_idex = mux_flush_idex & ~CLR;

  assign PC         = pc_q;
  assign eret       = eret_q;
  assign in_handler = (state_q == HANDLER);
  assign int_cnt    = int_cnt_q;
  assign hcycles    = hcycles_q;
  assign err        = err_q;

  // Next state, return pulse, counters and sticky error from this cycle's requests
  always_comb begin
    state_d   = state_q;
    eret_d    = 1'b0;
    int_cnt_d = int_cnt_q;
    hcycles_d = hcycles_q;
    err_d     = err_q;
    if (state_q == HANDLER && hcycles_q != {CNT_W{1'b1}}) begin
      hcycles_d = hcycles_q + CNT_W'(1);
    end
    if (Int && (state_q == RUN)) begin
      state_d   = HANDLER;
      int_cnt_d = int_cnt_q + 8'd1;
      hcycles_d = '0;
    end else if (eret_dec && (state_q == HANDLER)) begin
      state_d = RUN;
      eret_d  = 1'b1;
    end
    if ((Int && (state_q == HANDLER)) || (eret_dec && (state_q == RUN))) begin
      err_d = 1'b1;
    end
  end

  // State, PC and bookkeeping registers, cleared asynchronously by CLR
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      eret_q    <= 1'b0;
      int_cnt_q <= 8'd0;
      hcycles_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      eret_q    <= eret_d;
      int_cnt_q <= int_cnt_d;
      hcycles_q <= hcycles_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_int_pc_seq.sv
// Bench for the interrupt entry/return sequencer: directed scenarios plus a
// randomized run, all checked against a rule-level model of the sequencer.
module tb_int_pc_seq;
  import int_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int HC_MAX   = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                CLR;
  logic                Int;
  logic [31:0]         Iaddr;
  logic [31:0]         EPC;
  logic                eret_dec;
  logic                J;
  logic [31:0]         Jaddr;
  logic                B;
  logic [31:0]         Baddr;
  logic                stall;
  logic [31:0]         PC;
  logic [31:0]         PC_plus1;
  logic                flush_ifid;
  logic                flush_idex;
  logic                eret;
  logic                in_handler;
  logic [7:0]          int_cnt;
  logic [TB_CNT_W-1:0] hcycles;
  logic                err;

  int tests = 0;
  int fails = 0;

  // Model state: what the sequencer should show after the last edge
  longint mPc;
  bit     mHand;
  int     mCnt;
  int     mHc;
  bit     mErr;
  bit     mEret;
  // Model prediction for the cycle in progress
  longint nPc;
  bit     nHand;
  int     nCnt;
  int     nHc;
  bit     nErr;
  bit     nEret;
  bit     expFi;
  bit     expFe;

  int_pc_seq #(.RESET_PC(DEFAULT_RESET_PC), .CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .CLR        (CLR),
    .Int        (Int),
    .Iaddr      (Iaddr),
    .EPC        (EPC),
    .eret_dec   (eret_dec),
    .J          (J),
    .Jaddr      (Jaddr),
    .B          (B),
    .Baddr      (Baddr),
    .stall      (stall),
    .PC         (PC),
    .PC_plus1   (PC_plus1),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .eret       (eret),
    .in_handler (in_handler),
    .int_cnt    (int_cnt),
    .hcycles    (hcycles),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the bench itself goes wrong
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_idle();
    Int = 1'b0; Iaddr = 32'h0; EPC = 32'h0; eret_dec = 1'b0;
    J = 1'b0; Jaddr = 32'h0; B = 1'b0; Baddr = 32'h0; stall = 1'b0;
  endtask

  task automatic model_reset();
    mPc = 64'(DEFAULT_RESET_PC); mHand = 0; mCnt = 0; mHc = 0; mErr = 0; mEret = 0;
  endtask

  // Apply the sequencer rules to the current inputs
  task automatic predict();
    bit takeInt, takeRet;
    takeInt = Int && !mHand;
    takeRet = eret_dec && mHand;
    nErr  = mErr || (Int && mHand) || (eret_dec && !mHand);
    nEret = takeRet;
    nCnt  = takeInt ? (mCnt + 1) % 256 : mCnt;
    if (takeInt)    nHc = 0;
    else if (mHand) nHc = (mHc + 1 > HC_MAX) ? HC_MAX : mHc + 1;
    else            nHc = mHc;
    nHand = takeInt ? 1'b1 : (takeRet ? 1'b0 : mHand);
    expFi = 1; expFe = 1;
    if (takeInt)      nPc = 64'(Iaddr);
    else if (takeRet) nPc = 64'(EPC);
    else if (B)       nPc = 64'(Baddr);
    else if (J)     begin nPc = 64'(Jaddr); expFe = 0; end
    else if (stall) begin nPc = mPc; expFi = 0; expFe = 0; end
    else            begin nPc = (mPc + 1) % 64'h1_0000_0000; expFi = 0; expFe = 0; end
  endtask

  // Let the settled inputs act at the next edge and move the model forward
  task automatic advance();
    @(posedge clk);
    #1;
    mPc = nPc; mHand = nHand; mCnt = nCnt; mHc = nHc; mErr = nErr; mEret = nEret;
  endtask

  task automatic test_reset();
    set_idle();
    Int = 1'b1; B = 1'b1; Baddr = 32'h55; Iaddr = IR2_ADDR;
    CLR = 1'b1;
    #12;
    tests++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin fails++; $display("[TB] FAIL reset_flush: got %b%b expected 00", flush_ifid, flush_idex); end
    tests++; if (PC !== 32'h0) begin fails++; $display("[TB] FAIL reset_pc: got %h expected 00000000", PC); end
    tests++; if (PC_plus1 !== 32'h1) begin fails++; $display("[TB] FAIL reset_pc_plus1: got %h expected 00000001", PC_plus1); end
    tests++; if ({in_handler, eret, err} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {in_handler, eret, err}); end
    tests++; if (int_cnt !== 8'd0 || hcycles !== '0) begin fails++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", int_cnt, hcycles); end
    set_idle();
    @(negedge clk);
    CLR = 1'b0;
    model_reset();
  endtask

  task automatic test_free_run();
    tests++; if (PC !== 32'h0) begin fails++; $display("[TB] FAIL free_start: got %h expected 00000000", PC); end
    for (int i = 1; i <= 4; i++) begin
      set_idle();
      #1;
      predict();
      tests++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin fails++; $display("[TB] FAIL free_flush%0d: got %b%b expected 00", i, flush_ifid, flush_idex); end
      advance();
      tests++; if (PC !== 32'(i) || in_handler !== 1'b0) begin fails++; $display("[TB] FAIL free_pc%0d: got %h/%b expected %h/0", i, PC, in_handler, 32'(i)); end
    end
  endtask

  task automatic test_entry_return();
    set_idle(); J = 1'b1; Jaddr = 32'h20;
    #1; predict(); advance();
    tests++; if (PC !== 32'h20) begin fails++; $display("[TB] FAIL er_setup: got %h expected 00000020", PC); end
    set_idle(); Int = 1'b1; Iaddr = IR2_ADDR;
    #1; predict();
    tests++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin fails++; $display("[TB] FAIL er_int_flush: got %b%b expected 11", flush_ifid, flush_idex); end
    advance();
    tests++; if (PC !== 32'hC8 || in_handler !== 1'b1 || int_cnt !== 8'd1) begin fails++; $display("[TB] FAIL er_entry: got pc=%h h=%b cnt=%0d expected pc=000000c8 h=1 cnt=1", PC, in_handler, int_cnt); end
    for (int i = 0; i < 5; i++) begin
      set_idle(); #1; predict(); advance();
    end
    tests++; if (PC !== 32'hCD) begin fails++; $display("[TB] FAIL er_handler_pc: got %h expected 000000cd", PC); end
    set_idle(); eret_dec = 1'b1; EPC = 32'h21;
    #1; predict();
    tests++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin fails++; $display("[TB] FAIL er_ret_flush: got %b%b expected 11", flush_ifid, flush_idex); end
    advance();
    tests++; if (PC !== 32'h21 || eret !== 1'b1 || in_handler !== 1'b0) begin fails++; $display("[TB] FAIL er_return: got pc=%h eret=%b h=%b expected 00000021 1 0", PC, eret, in_handler); end
    tests++; if (hcycles !== 4'd6) begin fails++; $display("[TB] FAIL er_hcycles: got %0d expected 6", hcycles); end
    set_idle(); #1; predict(); advance();
    tests++; if (eret !== 1'b0 || PC !== 32'h22 || hcycles !== 4'd6) begin fails++; $display("[TB] FAIL er_after: got eret=%b pc=%h hc=%0d expected 0 00000022 6", eret, PC, hcycles); end
  endtask

  task automatic test_redirects();
    set_idle(); stall = 1'b1; B = 1'b1; Baddr = 32'h40; J = 1'b1; Jaddr = 32'h77;
    #1; predict();
    tests++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin fails++; $display("[TB] FAIL rd_branch_flush: got %b%b expected 11", flush_ifid, flush_idex); end
    advance();
    tests++; if (PC !== 32'h40) begin fails++; $display("[TB] FAIL rd_branch_pc: got %h expected 00000040", PC); end
    set_idle(); stall = 1'b1;
    #1; predict();
    tests++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin fails++; $display("[TB] FAIL rd_stall_flush: got %b%b expected 00", flush_ifid, flush_idex); end
    advance();
    tests++; if (PC !== 32'h40) begin fails++; $display("[TB] FAIL rd_stall_pc: got %h expected 00000040", PC); end
    set_idle(); J = 1'b1; Jaddr = 32'h100;
    #1; predict();
    tests++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin fails++; $display("[TB] FAIL rd_jump_flush: got %b%b expected 10", flush_ifid, flush_idex); end
    advance();
    tests++; if (PC !== 32'h100) begin fails++; $display("[TB] FAIL rd_jump_pc: got %h expected 00000100", PC); end
    set_idle(); J = 1'b1; Jaddr = 32'hFFFF_FFFF;
    #1; predict(); advance();
    tests++; if (PC_plus1 !== 32'h0) begin fails++; $display("[TB] FAIL rd_wrap_plus1: got %h expected 00000000", PC_plus1); end
    set_idle(); #1; predict(); advance();
    tests++; if (PC !== 32'h0) begin fails++; $display("[TB] FAIL rd_wrap_pc: got %h expected 00000000", PC); end
  endtask

  task automatic test_int_in_handler();
    set_idle(); Int = 1'b1; Iaddr = IR2_ADDR;
    #1; predict(); advance();
    set_idle(); Int = 1'b1; Iaddr = IR1_ADDR;
    #1; predict();
    tests++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin fails++; $display("[TB] FAIL ih_flush: got %b%b expected 00", flush_ifid, flush_idex); end
    advance();
    tests++; if (PC !== 32'hC9 || err !== 1'b1 || in_handler !== 1'b1) begin fails++; $display("[TB] FAIL ih_ignored: got pc=%h err=%b h=%b expected 000000c9 1 1", PC, err, in_handler); end
    set_idle(); eret_dec = 1'b1; EPC = 32'h300;
    #1; predict(); advance();
    tests++; if (PC !== 32'h300 || err !== 1'b1 || eret !== 1'b1) begin fails++; $display("[TB] FAIL ih_return: got pc=%h err=%b eret=%b expected 00000300 1 1", PC, err, eret); end
    set_idle(); Int = 1'b1; Iaddr = IR3_ADDR;
    #1; predict(); advance();
    tests++; if (PC !== 32'h16C || in_handler !== 1'b1 || eret !== 1'b0 || int_cnt !== 8'(mCnt)) begin fails++; $display("[TB] FAIL ih_reentry: got pc=%h h=%b eret=%b cnt=%0d expected 0000016c 1 0 %0d", PC, in_handler, eret, int_cnt, mCnt); end
    set_idle(); eret_dec = 1'b1; EPC = 32'h304;
    #1; predict(); advance();
    set_idle(); eret_dec = 1'b1; B = 1'b1; Baddr = 32'h500;
    #1; predict(); advance();
    tests++; if (PC !== 32'h500 || eret !== 1'b0 || in_handler !== 1'b0) begin fails++; $display("[TB] FAIL ih_stray_eret: got pc=%h eret=%b h=%b expected 00000500 0 0", PC, eret, in_handler); end
  endtask

  task automatic test_hcycles_saturate();
    set_idle(); Int = 1'b1; Iaddr = IR1_ADDR;
    #1; predict(); advance();
    for (int i = 0; i < HC_MAX + 5; i++) begin
      set_idle(); #1; predict(); advance();
    end
    tests++; if (hcycles !== 4'(HC_MAX)) begin fails++; $display("[TB] FAIL hc_saturate: got %0d expected %0d", hcycles, HC_MAX); end
    set_idle(); eret_dec = 1'b1; EPC = 32'h80;
    #1; predict(); advance();
    for (int i = 0; i < 3; i++) begin
      set_idle(); #1; predict(); advance();
    end
    tests++; if (hcycles !== 4'(HC_MAX) || PC !== 32'h83) begin fails++; $display("[TB] FAIL hc_hold_run: got hc=%0d pc=%h expected %0d 00000083", hcycles, PC, HC_MAX); end
  endtask

  task automatic test_int_cnt_wrap();
    int startCnt;
    startCnt = mCnt;
    for (int i = 0; i < 256; i++) begin
      set_idle(); Int = 1'b1; Iaddr = IR3_ADDR;
      #1; predict(); advance();
      set_idle(); eret_dec = 1'b1; EPC = $urandom;
      #1; predict(); advance();
    end
    tests++; if (int_cnt !== 8'(startCnt) || int_cnt !== 8'(mCnt)) begin fails++; $display("[TB] FAIL cnt_wrap: got %0d expected %0d", int_cnt, startCnt); end
  endtask

  task automatic test_async_clr();
    set_idle(); Int = 1'b1; Iaddr = IR2_ADDR;
    #1; predict(); advance();
    set_idle(); #1; predict(); advance();
    set_idle(); eret_dec = 1'b1; EPC = 32'h44;
    #2;
    CLR = 1'b1;
    #1;
    tests++; if (PC !== 32'h0 || in_handler !== 1'b0) begin fails++; $display("[TB] FAIL clr_immediate: got pc=%h h=%b expected 00000000 0", PC, in_handler); end
    tests++; if ({eret, err, flush_ifid, flush_idex} !== 4'b0000) begin fails++; $display("[TB] FAIL clr_quiet: got %b expected 0000", {eret, err, flush_ifid, flush_idex}); end
    @(posedge clk); #1;
    tests++; if (PC !== 32'h0 || eret !== 1'b0 || int_cnt !== 8'd0) begin fails++; $display("[TB] FAIL clr_held: got pc=%h eret=%b cnt=%0d expected 00000000 0 0", PC, eret, int_cnt); end
    set_idle();
    @(negedge clk);
    CLR = 1'b0;
    model_reset();
    #1; predict(); advance();
    tests++; if (PC !== 32'h1 || eret !== 1'b0) begin fails++; $display("[TB] FAIL clr_resume: got pc=%h eret=%b expected 00000001 0", PC, eret); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Int      = ($urandom_range(0, 9) == 0);
      Iaddr    = ($urandom_range(0, 1) == 0) ? IR2_ADDR : 32'($urandom);
      eret_dec = ($urandom_range(0, 5) == 0);
      EPC      = 32'($urandom);
      B        = ($urandom_range(0, 9) == 0);
      Baddr    = 32'($urandom);
      J        = ($urandom_range(0, 9) == 0);
      Jaddr    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : {6'b0, 26'($urandom)};
      stall    = ($urandom_range(0, 4) == 0);
      #1; predict();
      tests++; if (flush_ifid !== expFi || flush_idex !== expFe) begin fails++; $display("[TB] FAIL rnd_flush@%0d: got %b%b expected %b%b", i, flush_ifid, flush_idex, expFi, expFe); end
      tests++; if (PC_plus1 !== 32'((mPc + 1) % 64'h1_0000_0000)) begin fails++; $display("[TB] FAIL rnd_plus1@%0d: got %h expected %h", i, PC_plus1, 32'((mPc + 1) % 64'h1_0000_0000)); end
      advance();
      tests++; if (PC !== 32'(mPc) || in_handler !== mHand || eret !== mEret) begin fails++; $display("[TB] FAIL rnd_pc@%0d: got pc=%h h=%b eret=%b expected %h %b %b", i, PC, in_handler, eret, 32'(mPc), mHand, mEret); end
      tests++; if (int_cnt !== 8'(mCnt) || hcycles !== 4'(mHc) || err !== mErr) begin fails++; $display("[TB] FAIL rnd_cnt@%0d: got cnt=%0d hc=%0d err=%b expected %0d %0d %b", i, int_cnt, hcycles, err, mCnt, mHc, mErr); end
    end
  endtask

  initial begin
    CLR = 1'b0;
    set_idle();
    model_reset();
    #2;
    test_reset();
    test_free_run();
    test_entry_return();
    test_redirects();
    test_int_in_handler();
    test_hcycles_saturate();
    test_int_cnt_wrap();
    test_async_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
